// File: rtl/restoring_divider_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : restoring_divider_pkg
// Purpose  : Shared types and constants for the 8-bit by 4-bit restoring
//            divider: FSM state encoding, operand widths, iteration count
//            and the quotient value reported on divide-by-zero.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package restoring_divider_pkg;

  localparam int DIVIDEND_W = 8;
  localparam int DIVISOR_W  = 4;
  localparam int ITERATIONS = 8;

  // One extra bit over the divisor so the shifted partial remainder can
  // never overflow the compare/subtract.
  localparam int REM_W      = DIVISOR_W + 1;

  // Counter must hold the value ITERATIONS itself.
  localparam int CNT_W      = $clog2(ITERATIONS + 1);

  localparam logic [DIVIDEND_W-1:0] DBZ_QUOTIENT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : restoring_divider_pkg
`default_nettype wire

// File: rtl/restoring_divider_div_step.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : div_step
// Purpose  : One combinational restoring-division step. Compares the
//            (already shifted) partial remainder against the zero-extended
//            divisor and subtracts when it fits.
// Ports    : rem_in  [REM_W-1:0]     shifted partial remainder
//            divisor [DIVISOR_W-1:0] divisor
//            rem_out [REM_W-1:0]     restored / reduced partial remainder
//            q_bit                   new quotient bit
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module div_step
  import restoring_divider_pkg::*;
(
  input  logic [REM_W-1:0]     rem_in,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [REM_W-1:0]     rem_out,
  output logic                 q_bit
);

  logic [REM_W-1:0] divisor_ext;
  logic [REM_W-1:0] diff;

  assign divisor_ext = {1'b0, divisor};
  assign diff        = rem_in - divisor_ext;

  always_comb begin
    q_bit   = 1'b0;
    rem_out = rem_in;
    if (rem_in >= divisor_ext) begin
      q_bit   = 1'b1;
      rem_out = diff;
    end
  end

endmodule : div_step
`default_nettype wire

// File: rtl/restoring_divider.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : restoring_divider
// Purpose  : Sequential unsigned restoring divider, 8-bit dividend by 4-bit
//            divisor, one quotient bit per clock, MSB first. A start pulse
//            accepted in IDLE yields done nine cycles later (or on the next
//            cycle for a zero divisor).
// Ports    : clk          clock, rising edge
//            rst_n        asynchronous active-low reset
//            start        request pulse, only sampled in IDLE
//            dividend[7:0], divisor[3:0]  operands, captured on accept
//            busy         high while iterating (RUN)
//            done         one-cycle completion pulse
//            quotient[7:0], remainder[3:0], div_by_zero  registered results
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module restoring_divider
  import restoring_divider_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ITERATIONS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  state_t                 state;
  state_t                 state_next;

  // Working registers. The dividend register doubles as the quotient
  // accumulator: each step shifts one dividend bit out of the top and one
  // quotient bit in at the bottom.
  logic [DIVIDEND_W-1:0]  dvd_reg;
  logic [DIVISOR_W-1:0]   dsr_reg;
  logic [REM_W-1:0]       prem;
  logic [CNT_W-1:0]       cnt;

  logic                   accept;
  logic                   accept_zero;
  logic                   stepping;
  logic                   last_step;

  logic [REM_W-1:0]       step_in;
  logic [REM_W-1:0]       step_rem;
  logic                   step_q;
  logic [DIVIDEND_W-1:0]  dvd_shifted;

  // After a restoring step the partial remainder is always below the
  // divisor, so its top bit is zero and drops out of the left shift.
  logic                   prem_msb_unused;
  assign prem_msb_unused = prem[REM_W-1];

  //----------------------------------------------------------------------------
  // Control strobes
  //----------------------------------------------------------------------------
  assign accept      = (state == IDLE) && start;
  assign accept_zero = accept && (divisor == '0);
  assign stepping    = (state == RUN);
  assign last_step   = stepping && (cnt == CNT_LAST);

  //----------------------------------------------------------------------------
  // State register
  //----------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  //----------------------------------------------------------------------------
  // Next-state and state-decoded outputs
  //----------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (divisor == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == CNT_LAST) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  //----------------------------------------------------------------------------
  // Restoring step: shift {prem, dvd_reg} left by one, then compare/subtract
  //----------------------------------------------------------------------------
  assign step_in = {prem[REM_W-2:0], dvd_reg[DIVIDEND_W-1]};

  div_step u_div_step (
    .rem_in  (step_in),
    .divisor (dsr_reg),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  assign dvd_shifted = {dvd_reg[DIVIDEND_W-2:0], step_q};

  //----------------------------------------------------------------------------
  // Working registers
  //----------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_reg <= '0;
      dsr_reg <= '0;
      prem    <= '0;
      cnt     <= '0;
    end else if (accept) begin
      dvd_reg <= dividend;
      dsr_reg <= divisor;
      prem    <= '0;
      cnt     <= CNT_LOAD;
    end else if (stepping) begin
      dvd_reg <= dvd_shifted;
      prem    <= step_rem;
      cnt     <= cnt - CNT_W'(1);
    end
  end

  //----------------------------------------------------------------------------
  // Result registers: only written on completion, otherwise they hold
  //----------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept_zero) begin
      quotient    <= DBZ_QUOTIENT;
      remainder   <= '0;
      div_by_zero <= 1'b1;
    end else if (last_step) begin
      quotient    <= dvd_shifted;
      remainder   <= step_rem[DIVISOR_W-1:0];
      div_by_zero <= 1'b0;
    end
  end

endmodule : restoring_divider
`default_nettype wire

// File: tb/tb_restoring_divider.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_restoring_divider
// Purpose  : Self-checking bench for restoring_divider. Each accepted start
//            pushes the reference result onto a scoreboard queue; a monitor
//            pops and compares it when done pulses, along with latency and
//            busy length.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_restoring_divider;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] q;
    logic [3:0] r;
    logic       dbz;
    int         cyc;
  } exp_t;

  exp_t sb[$];

  int total     = 0;
  int bad       = 0;
  int cycle     = 0;
  int busy_cnt  = 0;
  int done_seen = 0;

  restoring_divider dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: plain integer division.
  function automatic exp_t model(input logic [7:0] a, input logic [3:0] b);
    exp_t e;
    e.a   = a;
    e.b   = b;
    e.cyc = 0;
    if (b == 4'd0) begin
      e.q   = 8'hFF;
      e.r   = 4'h0;
      e.dbz = 1'b1;
    end else begin
      e.q   = 8'(int'(a) / int'(b));
      e.r   = 4'(int'(a) % int'(b));
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Monitor: sample away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        done_seen++;
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("quotient",    32'(quotient),    32'(e.q));
          check("remainder",   32'(remainder),   32'(e.r));
          check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
          check("latency",     32'(cycle - e.cyc), e.dbz ? 32'd0 : 32'd8);
          check("busy_len",    32'(busy_cnt),    e.dbz ? 32'd0 : 32'd8);
          if (!e.dbz) begin
            check("roundtrip", 32'(int'(quotient) * int'(e.b) + int'(remainder)), 32'(e.a));
            check("rem_lt_div", 32'(remainder < e.b), 32'd1);
          end
        end
        busy_cnt = 0;
      end
    end
  end

  // Drive one request from IDLE; the entry is pushed once the accepting
  // edge has passed, tagged with the cycle count at that edge.
  task automatic launch(input logic [7:0] a, input logic [3:0] b);
    exp_t e;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    e     = model(a, b);
    e.cyc = cycle;
    sb.push_back(e);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({tag, "_complete"}, 32'(sb.size() == 0), 32'd1);
    if (sb.size() != 0) sb.delete();
  endtask

  task automatic run_op(input logic [7:0] a, input logic [3:0] b, input string tag);
    launch(a, b);
    wait_done(tag);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 4'd0;
    #1;
    check("rst_busy", 32'(busy),        32'd0);
    check("rst_done", 32'(done),        32'd0);
    check("rst_q",    32'(quotient),    32'd0);
    check("rst_r",    32'(remainder),   32'd0);
    check("rst_dbz",  32'(div_by_zero), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Basic and corner operands.
    run_op(8'd200, 4'd7, "basic");
    repeat (3) @(negedge clk);
    check("hold_q", 32'(quotient),  32'd28);
    check("hold_r", 32'(remainder), 32'd4);
    run_op(8'd255, 4'd15, "c255_15");
    run_op(8'd5,   4'd9,  "c5_9");
    run_op(8'd0,   4'd3,  "c0_3");
    run_op(8'd255, 4'd1,  "c255_1");

    // Divide by zero, then a normal division clears the flag.
    run_op(8'd100, 4'd0,  "dbz");
    run_op(8'd100, 4'd10, "after_dbz");

    // Start and operand changes during RUN must be ignored.
    d0 = done_seen;
    launch(8'd200, 4'd7);
    repeat (2) @(negedge clk);
    start    = 1'b1;
    dividend = 8'd9;
    divisor  = 4'd3;
    @(negedge clk);
    start    = 1'b0;
    dividend = 8'h55;
    divisor  = 4'h0;
    wait_done("interfere");
    repeat (4) @(negedge clk);
    check("interfere_one_done", 32'(done_seen - d0), 32'd1);

    // Back-to-back: launch() starts on the IDLE cycle right after DONE.
    launch(8'd77, 4'd6);
    wait_done("b2b_first");
    launch(8'd250, 4'd13);
    wait_done("b2b_second");

    // Reset mid-run: outputs clear immediately, no done for the aborted op.
    d0 = done_seen;
    launch(8'd200, 4'd7);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("midrst_busy", 32'(busy),        32'd0);
    check("midrst_done", 32'(done),        32'd0);
    check("midrst_q",    32'(quotient),    32'd0);
    check("midrst_r",    32'(remainder),   32'd0);
    check("midrst_dbz",  32'(div_by_zero), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("midrst_no_done", 32'(done_seen - d0), 32'd0);
    run_op(8'd50, 4'd5, "after_rst");

    // Exact multiples: x*y / y == x r 0.
    for (int y = 1; y <= 15; y++) begin
      for (int x = 1; x <= 15; x++) begin
        run_op(8'(x * y), 4'(y), "multiple");
      end
    end

    // Random pairs, including occasional zero divisors.
    for (int i = 0; i < 200; i++) begin
      run_op(8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)), "random");
    end

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_restoring_divider
`default_nettype wire
